// File: rtl/mdp3_pkg.sv
// Shared types and constants for the MDP3 snapshot streaming path.
package mdp3_pkg;

  // One book level record: [87:24] price, [23:8] quantity, [7:0] num_orders.
  localparam int LEVEL_W   = 88;
  localparam int PRICE_LSB = 24;
  localparam int QTY_LSB   = 8;
  localparam int PRICE_W   = 64;
  localparam int QTY_W     = 16;
  localparam int ORD_W     = 8;

  typedef struct packed {
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   quantity;
    logic [ORD_W-1:0]   num_orders;
  } book_level_t;

  // Snapshot serializer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HDR   = 2'd1,
    S_PRICE = 2'd2,
    S_QTY   = 2'd3
  } snap_state_e;

  // Bit 7 of the tag byte.
  localparam logic TAG_SIDE_BID = 1'b0;
  localparam logic TAG_SIDE_ASK = 1'b1;

endpackage

// File: rtl/snapshot_beat_mux.sv
// Forms the current stream beat from the serializer state, the level index
// and the captured snapshot. Purely combinational.
module snapshot_beat_mux
  import mdp3_pkg::*;
#(
  parameter int NUM_LEVELS = 10,
  parameter int LEVEL_W    = mdp3_pkg::LEVEL_W,
  parameter int IDX_W      = 5
) (
  input  snap_state_e                   state,
  input  logic [IDX_W-1:0]              index,
  input  logic [31:0]                   security_id,
  input  logic [31:0]                   seq,
  input  logic [NUM_LEVELS*LEVEL_W-1:0] bid_book,
  input  logic [NUM_LEVELS*LEVEL_W-1:0] ask_book,
  output logic [63:0]                   beat,
  output logic                          sop,
  output logic                          eop
);

  // Index 0..N-1 addresses bids, N..2N-1 asks; unused slots read as zero so
  // the lookup never goes out of range.
  logic [LEVEL_W-1:0] level_table [2**IDX_W];

  genvar gi;
  for (gi = 0; gi < 2**IDX_W; gi++) begin : g_table
    if (gi < NUM_LEVELS) begin : g_bid
      assign level_table[gi] = bid_book[gi*LEVEL_W +: LEVEL_W];
    end else if (gi < 2*NUM_LEVELS) begin : g_ask
      assign level_table[gi] = ask_book[(gi-NUM_LEVELS)*LEVEL_W +: LEVEL_W];
    end else begin : g_pad
      assign level_table[gi] = '0;
    end
  end

  logic [LEVEL_W-1:0] rec;
  book_level_t        lvl;
  logic               side;
  logic [IDX_W-1:0]   lvl_idx;

  // Decode the selected record and build the beat for the current state.
  always_comb begin
    rec            = level_table[index];
    lvl.price      = rec[PRICE_LSB +: PRICE_W];
    lvl.quantity   = rec[QTY_LSB +: QTY_W];
    lvl.num_orders = rec[0 +: ORD_W];
    side           = (index >= IDX_W'(NUM_LEVELS)) ? TAG_SIDE_ASK : TAG_SIDE_BID;
    lvl_idx        = side ? (index - IDX_W'(NUM_LEVELS)) : index;
    beat           = '0;
    sop            = 1'b0;
    eop            = 1'b0;
    case (state)
      S_HDR: begin
        beat = {security_id, seq};
        sop  = 1'b1;
      end
      S_PRICE: beat = lvl.price;
      S_QTY: begin
        beat = {lvl.quantity, lvl.num_orders, side, 7'(lvl_idx), 32'h0};
        eop  = (index == IDX_W'(2*NUM_LEVELS-1));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/book_snapshot_streamer.sv
// Captures an order book snapshot on each orderbook_ready pulse and streams
// it as one Avalon-ST packet. Snapshots arriving while busy are dropped.
module book_snapshot_streamer
  import mdp3_pkg::*;
#(
  parameter int NUM_LEVELS = 10,
  parameter int LEVEL_W    = mdp3_pkg::LEVEL_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          orderbook_ready,
  input  logic [31:0]                   SECURITY_ID,
  input  logic [NUM_LEVELS*LEVEL_W-1:0] bid_levels,
  input  logic [NUM_LEVELS*LEVEL_W-1:0] ask_levels,
  output logic [63:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_startofpacket,
  output logic                          out_endofpacket,
  output logic [2:0]                    out_empty,
  output logic                          busy,
  output logic [15:0]                   dropped_count,
  output logic [31:0]                   seq_num
);

  localparam int IDX_W = $clog2(2*NUM_LEVELS);

  snap_state_e                   state;
  logic [IDX_W-1:0]              index;
  logic [31:0]                   seq;
  logic [31:0]                   security_id;
  logic [NUM_LEVELS*LEVEL_W-1:0] bid_book;
  logic [NUM_LEVELS*LEVEL_W-1:0] ask_book;

  logic fire;
  logic last_beat;
  logic last_accept;
  logic capture;
  logic drop;

  // Outputs are driven straight from registered state, so data/SOP/EOP hold
  // while the sink stalls and valid never drops mid-packet.
  assign out_valid   = (state != S_IDLE);
  assign busy        = out_valid;
  assign out_empty   = 3'd0;
  assign fire        = out_valid && out_ready;
  assign last_beat   = (state == S_QTY) && (index == IDX_W'(2*NUM_LEVELS-1));
  assign last_accept = last_beat && fire;
  // A pulse in the cycle the final beat leaves is taken back-to-back.
  assign capture     = orderbook_ready && ((state == S_IDLE) || last_accept);
  assign drop        = orderbook_ready && !capture;

  // Snapshot storage; only written on an accepted capture.
  always_ff @(posedge clk) begin
    if (capture && reset_n) begin
      bid_book    <= bid_levels;
      ask_book    <= ask_levels;
      security_id <= SECURITY_ID;
    end
  end

  // Serializer FSM and sequence numbering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      index   <= '0;
      seq     <= 32'hFFFF_FFFF;
      seq_num <= 32'd0;
    end else if (capture) begin
      state   <= S_HDR;
      index   <= '0;
      seq     <= seq + 32'd1;
      seq_num <= seq + 32'd1;
    end else if (fire) begin
      case (state)
        S_HDR:   state <= S_PRICE;
        S_PRICE: state <= S_QTY;
        S_QTY: begin
          if (last_beat) begin
            state <= S_IDLE;
            index <= '0;
          end else begin
            state <= S_PRICE;
            index <= index + IDX_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Saturating count of snapshots lost to a busy serializer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dropped_count <= 16'd0;
    end else if (drop && (dropped_count != 16'hFFFF)) begin
      dropped_count <= dropped_count + 16'd1;
    end
  end

  snapshot_beat_mux #(
    .NUM_LEVELS (NUM_LEVELS),
    .LEVEL_W    (LEVEL_W),
    .IDX_W      (IDX_W)
  ) u_beat_mux (
    .state       (state),
    .index       (index),
    .security_id (security_id),
    .seq         (seq),
    .bid_book    (bid_book),
    .ask_book    (ask_book),
    .beat        (out_data),
    .sop         (out_startofpacket),
    .eop         (out_endofpacket)
  );

endmodule

// File: tb/tb_book_snapshot_streamer.sv
// Scoreboard bench for book_snapshot_streamer: expected beats are queued
// when a snapshot pulse is driven and compared as the DUT emits them.
module tb_book_snapshot_streamer;

  localparam int N = 10;
  localparam int W = 88;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           orderbook_ready;
  logic [31:0]    sec_id;
  logic [N*W-1:0] bid_levels;
  logic [N*W-1:0] ask_levels;
  logic [63:0]    out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_startofpacket;
  logic           out_endofpacket;
  logic [2:0]     out_empty;
  logic           busy;
  logic [15:0]    dropped_count;
  logic [31:0]    seq_num;

  logic [63:0] bid_price [N];
  logic [63:0] ask_price [N];
  logic [15:0] bid_qty   [N];
  logic [15:0] ask_qty   [N];
  logic [7:0]  bid_ord   [N];
  logic [7:0]  ask_ord   [N];

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          beats_total = 0;
  int          ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  logic [31:0] exp_seq = 32'd0;
  logic [15:0] exp_drop = 16'd0;
  logic        stall_armed = 1'b0;
  logic [63:0] stall_data;
  logic [1:0]  stall_ctrl;

  book_snapshot_streamer #(.NUM_LEVELS(N), .LEVEL_W(W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .orderbook_ready   (orderbook_ready),
    .SECURITY_ID       (sec_id),
    .bid_levels        (bid_levels),
    .ask_levels        (ask_levels),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .busy              (busy),
    .dropped_count     (dropped_count),
    .seq_num           (seq_num)
  );

  always #5 clk = ~clk;

  // Record layout: [87:24] price, [23:8] quantity, [7:0] orders.
  always_comb begin
    bid_levels = '0;
    ask_levels = '0;
    for (int k = 0; k < N; k++) begin
      bid_levels[k*W +: W] = {bid_price[k], bid_qty[k], bid_ord[k]};
      ask_levels[k*W +: W] = {ask_price[k], ask_qty[k], ask_ord[k]};
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_book_basic();
    for (int k = 0; k < N; k++) begin
      bid_price[k] = 64'(100 + k);
      bid_qty[k]   = 16'(10 + k);
      bid_ord[k]   = 8'(k);
      ask_price[k] = 64'(200 + k);
      ask_qty[k]   = 16'(20 + k);
      ask_ord[k]   = 8'(k);
    end
  endtask

  task automatic set_book_random();
    for (int k = 0; k < N; k++) begin
      bid_price[k] = {$urandom, $urandom};
      bid_qty[k]   = 16'($urandom);
      bid_ord[k]   = 8'($urandom);
      ask_price[k] = {$urandom, $urandom};
      ask_qty[k]   = 16'($urandom);
      ask_ord[k]   = 8'($urandom);
    end
    sec_id = $urandom;
  endtask

  // Reference packet built from the bench's own copy of the book.
  task automatic push_packet();
    exp_t e;
    e.data = {sec_id, exp_seq};
    e.sop  = 1'b1;
    e.eop  = 1'b0;
    q.push_back(e);
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < N; k++) begin
        e.sop  = 1'b0;
        e.eop  = 1'b0;
        e.data = (s == 1) ? ask_price[k] : bid_price[k];
        q.push_back(e);
        if (s == 1) e.data = {ask_qty[k], ask_ord[k], 1'b1, 7'(k), 32'h0};
        else        e.data = {bid_qty[k], bid_ord[k], 1'b0, 7'(k), 32'h0};
        e.eop = (s == 1) && (k == N - 1);
        q.push_back(e);
      end
    end
    exp_seq = exp_seq + 32'd1;
  endtask

  // Called at posedge+1; holds orderbook_ready for exactly one edge.
  task automatic pulse(input bit expect_capture);
    orderbook_ready = 1'b1;
    if (expect_capture) push_packet();
    else if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    @(posedge clk); #1;
    orderbook_ready = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_done", 64'(q.size() != 0 || busy), 64'd0);
    q.delete();
  endtask

  task automatic wait_beats(input int start, input int count);
    int n;
    n = 0;
    while ((beats_total - start) < count && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("beat_wait", 64'((beats_total - start) >= count), 64'd1);
  endtask

  // Sink-side ready driver.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare each transferred beat and check stall stability.
  always @(negedge clk) begin
    if (stall_armed) begin
      check_eq("stall_data", out_data, stall_data);
      check_eq("stall_ctrl", 64'({out_valid, out_startofpacket, out_endofpacket}),
               64'({1'b1, stall_ctrl}));
    end
    stall_armed = reset_n && out_valid && !out_ready;
    stall_data  = out_data;
    stall_ctrl  = {out_startofpacket, out_endofpacket};
    if (reset_n && out_valid && out_ready) begin
      exp_t e;
      beats_total++;
      check_eq("beat_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check_eq("beat_data", out_data, e.data);
        check_eq("beat_ctrl", 64'({out_empty, out_startofpacket, out_endofpacket}),
                 64'({3'd0, e.sop, e.eop}));
      end
    end
  end

  initial begin
    int start;
    int n;
    reset_n         = 1'b0;
    orderbook_ready = 1'b0;
    sec_id          = 32'h1234;
    set_book_basic();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_data", out_data, 64'd0);
    check_eq("rst_sop_eop", 64'({out_startofpacket, out_endofpacket}), 64'd0);
    check_eq("rst_empty", 64'(out_empty), 64'd0);
    check_eq("rst_dropped", 64'(dropped_count), 64'd0);
    check_eq("rst_seq_num", 64'(seq_num), 64'd0);
    @(posedge clk); #1;

    // Basic: 41 beats back to back with out_ready held high.
    pulse(1'b1);
    check_eq("basic_latency_valid", 64'(out_valid), 64'd1);
    check_eq("basic_latency_sop", 64'(out_startofpacket), 64'd1);
    repeat (41) @(posedge clk);
    #1;
    check_eq("basic_no_bubbles", 64'(q.size() != 0 || busy), 64'd0);
    check_eq("basic_seq_num", 64'(seq_num), 64'd0);
    drain(10);

    // Backpressure: random ready, same book.
    ready_mode = 2;
    pulse(1'b1);
    drain(1000);
    ready_mode = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Drop: second pulse at beat 10 with a different book presented.
    set_book_random();
    pulse(1'b1);
    start = beats_total;
    wait_beats(start, 10);
    set_book_random();
    pulse(1'b0);
    drain(200);
    check_eq("drop_count", 64'(dropped_count), 64'(exp_drop));
    pulse(1'b1);
    drain(200);
    check_eq("drop_seq_num", 64'(seq_num), 64'(exp_seq - 32'd1));

    // Back-to-back: pulse in the cycle the EOP beat is accepted.
    set_book_random();
    pulse(1'b1);
    n = 0;
    while (!(out_valid && out_endofpacket) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("b2b_eop_seen", 64'(out_valid && out_endofpacket), 64'd1);
    set_book_random();
    pulse(1'b1);
    check_eq("b2b_valid", 64'(out_valid), 64'd1);
    check_eq("b2b_sop", 64'(out_startofpacket), 64'd1);
    check_eq("b2b_dropped", 64'(dropped_count), 64'(exp_drop));
    drain(200);
    check_eq("b2b_seq_num", 64'(seq_num), 64'(exp_seq - 32'd1));

    // Reset mid-packet at beat 20, with a pulse held during reset.
    set_book_basic();
    sec_id = 32'h1234;
    pulse(1'b1);
    start = beats_total;
    wait_beats(start, 20);
    reset_n         = 1'b0;
    orderbook_ready = 1'b1;
    @(posedge clk); #1;
    reset_n         = 1'b1;
    orderbook_ready = 1'b0;
    q.delete();
    exp_seq  = 32'd0;
    exp_drop = 16'd0;
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_data", out_data, 64'd0);
    check_eq("mid_rst_dropped", 64'(dropped_count), 64'd0);
    check_eq("mid_rst_seq_num", 64'(seq_num), 64'd0);
    @(posedge clk); #1;
    pulse(1'b1);
    drain(200);
    check_eq("post_rst_seq_num", 64'(seq_num), 64'd0);

    // Saturation: stall the sink and hold the pulse high past 65535 drops.
    ready_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pulse(1'b1);
    set_book_random();
    orderbook_ready = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check_eq("sat_below", 64'(dropped_count), 64'h0000_0000_0000_FFFE);
    repeat (10) @(posedge clk);
    #1;
    check_eq("sat_hold", 64'(dropped_count), 64'h0000_0000_0000_FFFF);
    orderbook_ready = 1'b0;
    ready_mode = 1;
    drain(200);
    check_eq("sat_after_drain", 64'(dropped_count), 64'h0000_0000_0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/book_snapshot_streamer.md
Name: book_snapshot_streamer

Overview:
- Sits directly downstream of Order_Book inside MDP3_STREAMER_TOP.
- On each orderbook_ready pulse, captures the 10 bid and 10 ask levels plus SECURITY_ID.
- Serializes the captured snapshot as one Avalon-ST packet: 64-bit beats with start/end packet, empty and valid/ready backpressure, feeding the host/DMA side.
- Busy snapshots are dropped and counted, never corrupted.

Parameters:
- NUM_LEVELS, 10, book depth per side; must match Order_Book depth.
- LEVEL_W, 88, width of one level record.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- orderbook_ready  input  1  one-cycle pulse: book levels valid this cycle.
- SECURITY_ID  input  32  instrument of current book.
- bid_levels  input  NUM_LEVELS*LEVEL_W  flattened BID0..BID9; BID0 at LSBs.
- ask_levels  input  NUM_LEVELS*LEVEL_W  flattened ASK0..ASK9; ASK0 at LSBs.
- out_data  output  64  stream data.
- out_valid  output  1  beat valid.
- out_ready  input  1  sink accepts beat.
- out_startofpacket  output  1  first beat of snapshot.
- out_endofpacket  output  1  last beat of snapshot.
- out_empty  output  3  always 0 (all beats full).
- busy  output  1  high from capture until last beat accepted.
- dropped_count  output  16  snapshots dropped while busy; saturates at 16'hFFFF.
- seq_num  output  32  sequence number of last captured snapshot.

Behaviour:
- Level record: [87:24] price, [23:8] quantity, [7:0] num_orders.
- Tag byte: bit7 side (0 = bid, 1 = ask); [6:0] level index.
- Packet is 1 + 4*NUM_LEVELS beats (41 by default):
  - Beat 0 (header): {SECURITY_ID, seq}.
  - Then, for BID0..BID(N-1) followed by ASK0..ASK(N-1), two beats per level:
    - Price beat: price[63:0].
    - Quantity beat: {quantity, num_orders, tag, 32'h0}.
- State machine: IDLE, HDR, PRICE, QTY.
  - A 5-bit (clog2(2*NUM_LEVELS)) level index selects the captured record.
- Capture: orderbook_ready with (state == IDLE, or last beat accepted this cycle):
  - Register all levels and SECURITY_ID.
  - seq increments: first snapshot after reset = 0; wraps 32'hFFFFFFFF -> 0.
  - Go to HDR.
  - out_valid = 1 with SOP on the next cycle (1-cycle latency).
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - out_data, SOP and EOP are held stable while out_valid && !out_ready.
  - out_valid is never deasserted mid-packet.
  - No bubbles when out_ready stays high: 41 consecutive beats.
- Transitions (each on transfer):
  - HDR -> PRICE.
  - PRICE -> QTY.
  - QTY -> PRICE with index+1, or to IDLE after the last ask.
  - On the back-to-back capture condition, QTY goes to HDR instead of IDLE.
- Drop: orderbook_ready while busy and not in the final-accept cycle:
  - Snapshot ignored; dropped_count += 1 (saturating).
  - Captured data unchanged.
- Reset (synchronous, reset_n low), all effective at the next clk edge:
  - state IDLE, index 0.
  - out_valid, SOP, EOP, busy = 0.
  - out_data = 0, out_empty = 0.
  - dropped_count = 0.
  - seq = 32'hFFFFFFFF internally; seq_num output reads 0.
- Reset mid-packet aborts without an EOP. The sink must tolerate this.
- orderbook_ready during reset is ignored.

Decomposition:
- Package mdp3_pkg holds:
  - LEVEL_W.
  - Field offsets (PRICE_LSB = 24, QTY_LSB = 8).
  - typedef book_level_t {price[63:0], quantity[15:0], num_orders[7:0]}.
  - State enum snap_state_e.
  - Tag side constants.
- Sub-module snapshot_beat_mux:
  - Combinational; selects the level and forms the beat from (state, index, captured arrays).
  - Keeps the FSM file small.

Test Plan:
- Basic:
  - Stimulus: BIDk price = 100+k, qty = 10+k, orders = k; ASKk price = 200+k, qty = 20+k, orders = k; SECURITY_ID 32'h1234; one pulse; out_ready = 1.
  - Response: 41 beats; beat0 = 64'h00001234_00000000 with SOP; beat1 = 100; beat2 = {16'd10, 8'd0, 8'h00, 32'h0}; beat40 = {16'd29, 8'd9, 8'h89, 32'h0} with EOP.
- Backpressure:
  - Stimulus: out_ready toggled with a random 50% duty.
  - Response: the same 41-beat sequence; data stable while stalled; no duplicated or missing beats.
- Drop:
  - Stimulus: a second pulse at beat 10, then a third pulse after IDLE.
  - Response: dropped_count = 1; the third packet header carries seq = 1.
- Back-to-back:
  - Stimulus: pulse in the same cycle the EOP beat is accepted.
  - Response: next cycle out_valid with SOP and seq + 1; dropped_count unchanged.
- Reset mid-packet:
  - Stimulus: reset_n low for 1 cycle at beat 20.
  - Response: next cycle out_valid = 0, busy = 0, counters 0; next pulse yields a full packet with seq 0.
- Saturation:
  - Stimulus: force 70000 drops.
  - Response: dropped_count = 16'hFFFF.
